midi_note_decoder: RTL and testbench

MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

---
 rtl/midi_note_decoder_pkg.sv | 16 +
 rtl/midi_note_decoder.sv | 126 ++++++++++++
 tb/tb_midi_note_decoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/midi_note_decoder_pkg.sv
// Shared constants and parser state encoding for the MIDI note decoder.
package midi_note_decoder_pkg;

  localparam logic [3:0] NOTE_OFF  = 4'h8;
  localparam logic [3:0] NOTE_ON   = 4'h9;
  localparam logic [3:0] PROG_CHG  = 4'hC;
  localparam logic [7:0] RT_THRESH = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NOTE_D1 = 2'd1,
    ST_NOTE_D2 = 2'd2,
    ST_PROG_D1 = 2'd3
  } parse_state_e;

endpackage

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI byte-stream parser: note on/off with running status and
// program change on one channel, last-note priority, change strobe.
module midi_note_decoder
  import midi_note_decoder_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [6:0] NOTE_NUM,
  output logic [6:0] NOTE_VEL,
  output logic       GATE,
  output logic [6:0] PROGRAM,
  output logic       NOTE_STB,
  output logic [1:0] STATE_DBG
);

  parse_state_e state_q, state_d;
  logic         note_on_q, note_on_d;
  logic [6:0]   pending_q, pending_d;
  logic [6:0]   note_num_q, note_num_d;
  logic [6:0]   note_vel_q, note_vel_d;
  logic         gate_q, gate_d;
  logic [6:0]   program_q, program_d;
  logic         note_stb_q, note_stb_d;

  logic       is_status;
  logic       is_rt;
  logic       chan_ok;
  logic [3:0] nib;
  logic       data_byte;

  assign is_status = RX_DATA[7];
  assign is_rt     = (RX_DATA >= RT_THRESH);
  assign nib       = RX_DATA[7:4];
  assign chan_ok   = (RX_DATA[3:0] == CHANNEL);
  assign data_byte = RX_VALID && !is_status;

  // State register (parser state plus latched running-status type)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      note_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_on_q <= note_on_d;
    end
  end

  // Next-state logic; real-time bytes fall through and leave everything alone
  always_comb begin
    state_d   = state_q;
    note_on_d = note_on_q;
    if (RX_VALID && is_status && !is_rt) begin
      if (chan_ok && (nib == NOTE_ON || nib == NOTE_OFF)) begin
        state_d   = ST_NOTE_D1;
        note_on_d = (nib == NOTE_ON);
      end else if (chan_ok && nib == PROG_CHG) begin
        state_d = ST_PROG_D1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (data_byte) begin
      case (state_q)
        ST_NOTE_D1: state_d = ST_NOTE_D2;
        ST_NOTE_D2: state_d = ST_NOTE_D1;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    pending_d  = pending_q;
    note_num_d = note_num_q;
    note_vel_d = note_vel_q;
    gate_d     = gate_q;
    program_d  = program_q;
    if (data_byte) begin
      case (state_q)
        ST_NOTE_D1: pending_d = RX_DATA[6:0];
        ST_NOTE_D2: begin
          if (note_on_q && RX_DATA[6:0] != 7'd0) begin
            note_num_d = pending_q;
            note_vel_d = RX_DATA[6:0];
            gate_d     = 1'b1;
          end else if (gate_q && pending_q == note_num_q) begin
            gate_d = 1'b0;
          end
        end
        ST_PROG_D1: program_d = RX_DATA[6:0];
        default: ;
      endcase
    end
    note_stb_d = (note_num_d != note_num_q) || (note_vel_d != note_vel_q) ||
                 (gate_d != gate_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q  <= 7'd0;
      note_num_q <= 7'd0;
      note_vel_q <= 7'd0;
      gate_q     <= 1'b0;
      program_q  <= 7'd0;
      note_stb_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      note_num_q <= note_num_d;
      note_vel_q <= note_vel_d;
      gate_q     <= gate_d;
      program_q  <= program_d;
      note_stb_q <= note_stb_d;
    end
  end

  assign NOTE_NUM  = note_num_q;
  assign NOTE_VEL  = note_vel_q;
  assign GATE      = gate_q;
  assign PROGRAM   = program_q;
  assign NOTE_STB  = note_stb_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed scenarios then random byte streams,
// compared against a message-assembly reference model after every cycle.
module tb_midi_note_decoder;
  import midi_note_decoder_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [6:0] NOTE_NUM;
  logic [6:0] NOTE_VEL;
  logic       GATE;
  logic [6:0] PROGRAM;
  logic       NOTE_STB;
  logic [1:0] STATE_DBG;

  int checks = 0;
  int errors = 0;

  // Reference model: running status byte (-1 = none) plus collected data bytes
  int       m_run;
  int       m_data[$];
  int       m_num, m_vel, m_gate, m_prog, m_stb;
  int       stb_count;

  midi_note_decoder #(.CHANNEL(4'd0)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .NOTE_NUM(NOTE_NUM), .NOTE_VEL(NOTE_VEL), .GATE(GATE), .PROGRAM(PROGRAM),
    .NOTE_STB(NOTE_STB), .STATE_DBG(STATE_DBG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = -1;
    m_data.delete();
    m_num = 0; m_vel = 0; m_gate = 0; m_prog = 0; m_stb = 0;
  endtask

  function automatic int model_state();
    if (m_run < 0) return int'(ST_IDLE);
    if ((m_run >> 4) == 12) return int'(ST_PROG_D1);
    return (m_data.size() == 0) ? int'(ST_NOTE_D1) : int'(ST_NOTE_D2);
  endfunction

  task automatic model_byte(input int b);
    int on_n, on_v, o_num, o_vel, o_gate, typ;
    m_stb = 0;
    if (b >= 248) return;
    if (b >= 128) begin
      typ = b >> 4;
      if ((b % 16) == 0 && (typ == 8 || typ == 9 || typ == 12)) m_run = b;
      else m_run = -1;
      m_data.delete();
      return;
    end
    if (m_run < 0) return;
    typ = m_run >> 4;
    if (typ == 12) begin
      m_prog = b;
      return;
    end
    m_data.push_back(b);
    if (m_data.size() < 2) return;
    on_n = m_data[0];
    on_v = m_data[1];
    m_data.delete();
    o_num = m_num; o_vel = m_vel; o_gate = m_gate;
    if (typ == 9 && on_v > 0) begin
      m_num = on_n; m_vel = on_v; m_gate = 1;
    end else if (m_gate == 1 && on_n == m_num) begin
      m_gate = 0;
    end
    m_stb = (o_num != m_num || o_vel != m_vel || o_gate != m_gate) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":note_num"}, 32'(NOTE_NUM), 32'(m_num));
    chk({tag, ":note_vel"}, 32'(NOTE_VEL), 32'(m_vel));
    chk({tag, ":gate"}, 32'(GATE), 32'(m_gate));
    chk({tag, ":program"}, 32'(PROGRAM), 32'(m_prog));
    chk({tag, ":note_stb"}, 32'(NOTE_STB), 32'(m_stb));
    chk({tag, ":state"}, 32'(STATE_DBG), 32'(model_state()));
    if (NOTE_STB === 1'b1) stb_count++;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    model_byte(int'(b));
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom_range(0, 255));
      m_stb    = 0;
      @(posedge CLK);
      #1;
      check_all(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RX_VALID = 1'b0;
    RST_N    = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    int chan;
    int nibs[3];
    int others[4];
    nibs   = '{8, 9, 12};
    others = '{10, 11, 13, 14};
    r = $urandom_range(0, 99);
    chan = $urandom_range(0, 3) == 0 ? 1 : 0;
    if (r < 20) return 8'(60 + $urandom_range(0, 3));
    if (r < 28) return 8'h00;
    if (r < 42) return 8'($urandom_range(0, 127));
    if (r < 60) return 8'(nibs[$urandom_range(0, 2)] * 16 + chan);
    if (r < 68) return 8'(others[$urandom_range(0, 3)] * 16);
    if (r < 76) return 8'($urandom_range(240, 247));
    if (r < 86) return 8'($urandom_range(248, 255));
    return 8'h90;
  endfunction

  initial begin
    RST_N     = 1'b0;
    RX_VALID  = 1'b0;
    RX_DATA   = 8'h00;
    stb_count = 0;
    model_reset();
    #1;
    check_all("reset_init");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    idle(2, "post_reset");

    // Basic note-on
    stb_count = 0;
    send(8'h90, "on_s"); send(8'h3C, "on_n"); send(8'h64, "on_v");
    idle(2, "on_idle");
    chk("on_num_const", 32'(NOTE_NUM), 32'd60);
    chk("on_vel_const", 32'(NOTE_VEL), 32'd100);
    chk("on_stb_once", 32'(stb_count), 32'd1);

    // Running status, then velocity-0 note-off
    send(8'h40, "rs_n"); send(8'h50, "rs_v");
    chk("rs_num_const", 32'(NOTE_NUM), 32'd64);
    send(8'h40, "rs0_n"); send(8'h00, "rs0_v");
    chk("rs0_gate_const", 32'(GATE), 32'd0);
    chk("rs0_num_const", 32'(NOTE_NUM), 32'd64);
    idle(1, "rs_idle");

    // Note-off mismatch and match
    send(8'h90, "mm_s"); send(8'h3C, "mm_n"); send(8'h64, "mm_v");
    stb_count = 0;
    send(8'h80, "mm_off"); send(8'h3E, "mm_off_n"); send(8'h40, "mm_off_v");
    chk("mm_no_stb", 32'(stb_count), 32'd0);
    send(8'h3C, "mm_hit_n"); send(8'h40, "mm_hit_v");
    chk("mm_gate_const", 32'(GATE), 32'd0);
    idle(1, "mm_idle");

    // Real-time interleave and foreign channel
    send(8'h90, "rt_s"); send(8'hF8, "rt_f8"); send(8'h3C, "rt_n");
    send(8'hFE, "rt_fe"); send(8'h64, "rt_v");
    chk("rt_num_const", 32'(NOTE_NUM), 32'd60);
    send(8'h91, "ch1_s"); send(8'h3D, "ch1_n"); send(8'h64, "ch1_v");
    idle(1, "rt_idle");

    // Program change and aborted message
    stb_count = 0;
    send(8'hC0, "pc_s"); send(8'h05, "pc_d");
    chk("pc_const", 32'(PROGRAM), 32'd5);
    chk("pc_no_stb", 32'(stb_count), 32'd0);
    send(8'h90, "ab_s"); send(8'h3E, "ab_n"); send(8'hB0, "ab_b0"); send(8'h7F, "ab_7f");
    chk("ab_state_const", 32'(STATE_DBG), 32'(ST_IDLE));
    send(8'h3C, "ab_disc");
    idle(1, "ab_idle");

    // Reset mid-message
    send(8'h90, "rm_s"); send(8'h3C, "rm_n");
    do_reset("rm_reset");
    send(8'h64, "rm_after");
    chk("rm_gate_const", 32'(GATE), 32'd0);
    idle(1, "rm_idle");

    // Random stream
    for (int i = 0; i < 600; i++) begin
      send(rand_byte(), "rnd");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), "rnd_idle");
      if ($urandom_range(0, 199) == 0) do_reset("rnd_reset");
    end
    idle(2, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
